// File: rtl/ldu_mq.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : ldu_mq                                                        |
// | Description : Misaligned-load queue; tracks the upper-word access of each   |
// |               misaligned load and re-issues it until it hits.              |
// | Revision    : 1.0 - initial release                                         |
// +----------------------------------------------------------------------------+
module ldu_mq #(
  parameter int LDU_MQ_ENTRIES     = 4,
  parameter int LOG_LDU_MQ_ENTRIES = $clog2(LDU_MQ_ENTRIES),
  parameter int LOG_LDU_CQ_ENTRIES = 4,
  parameter int PPN_WIDTH          = 22,
  parameter int VPN_WIDTH          = 20,
  parameter int PO_WIDTH           = 12
) (
  input  logic                          CLK,
  input  logic                          RST,
  input  logic                          ldu_mq_enq_valid,
  input  logic [LOG_LDU_CQ_ENTRIES-1:0] ldu_mq_enq_cq_index,
  input  logic [PO_WIDTH-3:0]           ldu_mq_enq_PO_word,
  input  logic [3:0]                    ldu_mq_enq_byte_mask,
  output logic                          ldu_mq_enq_ready,
  output logic [LOG_LDU_MQ_ENTRIES-1:0] ldu_mq_enq_index,
  input  logic [LOG_LDU_MQ_ENTRIES-1:0] ldu_mq_info_grab_mq_index,
  output logic [PPN_WIDTH-1:0]          ldu_mq_info_grab_PA_word,
  input  logic                          ldu_mq_info_ret_valid,
  input  logic [LOG_LDU_MQ_ENTRIES-1:0] ldu_mq_info_ret_mq_index,
  input  logic                          ldu_mq_info_ret_dtlb_hit,
  input  logic                          ldu_mq_info_ret_dcache_hit,
  input  logic                          ldu_mq_info_ret_is_mem,
  input  logic                          ldu_mq_info_ret_aq_blocking,
  input  logic [PPN_WIDTH-1:0]          ldu_mq_info_ret_PPN,
  input  logic [31:0]                   ldu_mq_info_ret_data,
  input  logic                          ldu_mq_wakeup_valid,
  output logic                          second_try_valid,
  output logic [PPN_WIDTH-1:0]          second_try_PPN,
  output logic [PO_WIDTH-3:0]           second_try_PO_word,
  output logic [3:0]                    second_try_byte_mask,
  output logic [LOG_LDU_CQ_ENTRIES-1:0] second_try_cq_index,
  output logic [LOG_LDU_MQ_ENTRIES-1:0] second_try_mq_index,
  input  logic                          second_try_ack,
  output logic                          ldu_mq_done_valid,
  output logic [LOG_LDU_CQ_ENTRIES-1:0] ldu_mq_done_cq_index,
  output logic                          ldu_mq_done_tlb_miss,
  output logic                          ldu_mq_done_is_mem,
  output logic [31:0]                   ldu_mq_done_data,
  input  logic                          ldu_mq_dealloc_valid,
  input  logic [LOG_LDU_MQ_ENTRIES-1:0] ldu_mq_dealloc_mq_index,
  input  logic                          ldu_mq_flush_valid
);

  localparam logic [2:0] c_ST_FREE      = 3'd0;
  localparam logic [2:0] c_ST_WAIT_RET  = 3'd1;
  localparam logic [2:0] c_ST_WAIT_WAKE = 3'd2;
  localparam logic [2:0] c_ST_READY     = 3'd3;
  localparam logic [2:0] c_ST_DONE      = 3'd4;

  logic [2:0]                    r_state     [LDU_MQ_ENTRIES];
  logic [2:0]                    w_state_nxt [LDU_MQ_ENTRIES];
  logic [LOG_LDU_CQ_ENTRIES-1:0] r_cq_index  [LDU_MQ_ENTRIES];
  logic [PO_WIDTH-3:0]           r_po_word   [LDU_MQ_ENTRIES];
  logic [3:0]                    r_byte_mask [LDU_MQ_ENTRIES];
  logic [PPN_WIDTH-1:0]          r_ppn       [LDU_MQ_ENTRIES];
  logic [31:0]                   r_data      [LDU_MQ_ENTRIES];
  logic                          r_is_mem    [LDU_MQ_ENTRIES];

  logic [LDU_MQ_ENTRIES-1:0]     w_free;
  logic [LDU_MQ_ENTRIES-1:0]     w_ready;
  logic [LOG_LDU_MQ_ENTRIES-1:0] w_enq_idx;
  logic [LOG_LDU_MQ_ENTRIES-1:0] w_sel_idx;
  logic                          w_sel_valid;
  logic                          w_enq_fire;
  logic                          w_ret_fire;
  logic                          w_ret_to_done;

  logic                          r_done_valid;
  logic [LOG_LDU_CQ_ENTRIES-1:0] r_done_cq_index;
  logic                          r_done_tlb_miss;
  logic                          r_done_is_mem;
  logic [31:0]                   r_done_data;

  generate
    for (genvar gi = 0; gi < LDU_MQ_ENTRIES; gi++) begin : g_entry
      assign w_free[gi]  = (r_state[gi] == c_ST_FREE);
      assign w_ready[gi] = (r_state[gi] == c_ST_READY);
    end
  endgenerate

  // Flush wins over every other event, so it gates all fire strobes.
  assign w_enq_fire    = ldu_mq_enq_valid & ldu_mq_enq_ready & ~ldu_mq_flush_valid;
  assign w_ret_fire    = ldu_mq_info_ret_valid & ~ldu_mq_flush_valid &
                         (r_state[ldu_mq_info_ret_mq_index] == c_ST_WAIT_RET);
  assign w_ret_to_done = ~ldu_mq_info_ret_dtlb_hit |
                         (ldu_mq_info_ret_dcache_hit & ~ldu_mq_info_ret_aq_blocking);

  // State register
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      for (int i = 0; i < LDU_MQ_ENTRIES; i++) r_state[i] <= c_ST_FREE;
    end else begin
      for (int i = 0; i < LDU_MQ_ENTRIES; i++) r_state[i] <= w_state_nxt[i];
    end
  end

  // Next-state logic; each event only acts on entries in its source state
  always_comb begin
    for (int i = 0; i < LDU_MQ_ENTRIES; i++) begin
      w_state_nxt[i] = r_state[i];
      if (ldu_mq_flush_valid) begin
        w_state_nxt[i] = c_ST_FREE;
      end else begin
        case (r_state[i])
          c_ST_FREE: begin
            if (w_enq_fire && (w_enq_idx == LOG_LDU_MQ_ENTRIES'(i)))
              w_state_nxt[i] = c_ST_WAIT_RET;
          end
          c_ST_WAIT_RET: begin
            if (ldu_mq_info_ret_valid && (ldu_mq_info_ret_mq_index == LOG_LDU_MQ_ENTRIES'(i)))
              w_state_nxt[i] = w_ret_to_done ? c_ST_DONE : c_ST_WAIT_WAKE;
          end
          c_ST_WAIT_WAKE: begin
            if (ldu_mq_wakeup_valid) w_state_nxt[i] = c_ST_READY;
          end
          c_ST_READY: begin
            if (second_try_ack && (w_sel_idx == LOG_LDU_MQ_ENTRIES'(i)))
              w_state_nxt[i] = c_ST_WAIT_RET;
          end
          c_ST_DONE: begin
            if (ldu_mq_dealloc_valid && (ldu_mq_dealloc_mq_index == LOG_LDU_MQ_ENTRIES'(i)))
              w_state_nxt[i] = c_ST_FREE;
          end
          default: w_state_nxt[i] = c_ST_FREE;
        endcase
      end
    end
  end

  // Output logic: lowest-index priority pick for allocation and re-issue
  always_comb begin
    w_enq_idx = '0;
    w_sel_idx = '0;
    for (int i = LDU_MQ_ENTRIES - 1; i >= 0; i--) begin
      if (w_free[i])  w_enq_idx = LOG_LDU_MQ_ENTRIES'(i);
      if (w_ready[i]) w_sel_idx = LOG_LDU_MQ_ENTRIES'(i);
    end
  end

  assign w_sel_valid              = |w_ready;
  assign ldu_mq_enq_ready         = |w_free;
  assign ldu_mq_enq_index         = w_enq_idx;
  assign ldu_mq_info_grab_PA_word = r_ppn[ldu_mq_info_grab_mq_index];

  assign second_try_valid     = w_sel_valid;
  assign second_try_PPN       = w_sel_valid ? r_ppn[w_sel_idx]       : '0;
  assign second_try_PO_word   = w_sel_valid ? r_po_word[w_sel_idx]   : '0;
  assign second_try_byte_mask = w_sel_valid ? r_byte_mask[w_sel_idx] : '0;
  assign second_try_cq_index  = w_sel_valid ? r_cq_index[w_sel_idx]  : '0;
  assign second_try_mq_index  = w_sel_valid ? w_sel_idx              : '0;

  // Per-entry payload
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      for (int i = 0; i < LDU_MQ_ENTRIES; i++) begin
        r_cq_index[i]  <= '0;
        r_po_word[i]   <= '0;
        r_byte_mask[i] <= '0;
        r_ppn[i]       <= '0;
        r_data[i]      <= '0;
        r_is_mem[i]    <= 1'b0;
      end
    end else begin
      for (int i = 0; i < LDU_MQ_ENTRIES; i++) begin
        if (w_enq_fire && (w_enq_idx == LOG_LDU_MQ_ENTRIES'(i))) begin
          r_cq_index[i]  <= ldu_mq_enq_cq_index;
          r_po_word[i]   <= ldu_mq_enq_PO_word;
          r_byte_mask[i] <= ldu_mq_enq_byte_mask;
        end
        if (w_ret_fire && ldu_mq_info_ret_dtlb_hit &&
            (ldu_mq_info_ret_mq_index == LOG_LDU_MQ_ENTRIES'(i))) begin
          r_ppn[i]    <= ldu_mq_info_ret_PPN;
          r_is_mem[i] <= ldu_mq_info_ret_is_mem;
          if (ldu_mq_info_ret_dcache_hit && !ldu_mq_info_ret_aq_blocking)
            r_data[i] <= ldu_mq_info_ret_data;
        end
      end
    end
  end

  // Completion pulse; only a RET result can move an entry into DONE
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_done_valid    <= 1'b0;
      r_done_cq_index <= '0;
      r_done_tlb_miss <= 1'b0;
      r_done_is_mem   <= 1'b0;
      r_done_data     <= '0;
    end else begin
      r_done_valid <= w_ret_fire & w_ret_to_done;
      if (w_ret_fire && w_ret_to_done) begin
        r_done_cq_index <= r_cq_index[ldu_mq_info_ret_mq_index];
        r_done_tlb_miss <= ~ldu_mq_info_ret_dtlb_hit;
        r_done_is_mem   <= ldu_mq_info_ret_dtlb_hit & ldu_mq_info_ret_is_mem;
        r_done_data     <= ldu_mq_info_ret_dtlb_hit ? ldu_mq_info_ret_data : 32'd0;
      end
    end
  end

  assign ldu_mq_done_valid    = r_done_valid;
  assign ldu_mq_done_cq_index = r_done_cq_index;
  assign ldu_mq_done_tlb_miss = r_done_tlb_miss;
  assign ldu_mq_done_is_mem   = r_done_is_mem;
  assign ldu_mq_done_data     = r_done_data;

endmodule
`default_nettype wire

// File: tb/tb_ldu_mq.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_ldu_mq                                                     |
// | Description : Self-checking bench for ldu_mq against a behavioural model.  |
// | Revision    : 1.0 - initial release                                         |
// +----------------------------------------------------------------------------+
module tb_ldu_mq;

  localparam int N    = 4;
  localparam int LOGN = 2;
  localparam int CQW  = 4;
  localparam int PPNW = 22;
  localparam int POW  = 10;

  typedef enum int {M_FREE, M_WRET, M_WWAKE, M_RDY, M_DONE} mst_t;

  logic            CLK = 1'b0;
  logic            RST;
  logic            ldu_mq_enq_valid;
  logic [CQW-1:0]  ldu_mq_enq_cq_index;
  logic [POW-1:0]  ldu_mq_enq_PO_word;
  logic [3:0]      ldu_mq_enq_byte_mask;
  logic            ldu_mq_enq_ready;
  logic [LOGN-1:0] ldu_mq_enq_index;
  logic [LOGN-1:0] ldu_mq_info_grab_mq_index;
  logic [PPNW-1:0] ldu_mq_info_grab_PA_word;
  logic            ldu_mq_info_ret_valid;
  logic [LOGN-1:0] ldu_mq_info_ret_mq_index;
  logic            ldu_mq_info_ret_dtlb_hit;
  logic            ldu_mq_info_ret_dcache_hit;
  logic            ldu_mq_info_ret_is_mem;
  logic            ldu_mq_info_ret_aq_blocking;
  logic [PPNW-1:0] ldu_mq_info_ret_PPN;
  logic [31:0]     ldu_mq_info_ret_data;
  logic            ldu_mq_wakeup_valid;
  logic            second_try_valid;
  logic [PPNW-1:0] second_try_PPN;
  logic [POW-1:0]  second_try_PO_word;
  logic [3:0]      second_try_byte_mask;
  logic [CQW-1:0]  second_try_cq_index;
  logic [LOGN-1:0] second_try_mq_index;
  logic            second_try_ack;
  logic            ldu_mq_done_valid;
  logic [CQW-1:0]  ldu_mq_done_cq_index;
  logic            ldu_mq_done_tlb_miss;
  logic            ldu_mq_done_is_mem;
  logic [31:0]     ldu_mq_done_data;
  logic            ldu_mq_dealloc_valid;
  logic [LOGN-1:0] ldu_mq_dealloc_mq_index;
  logic            ldu_mq_flush_valid;

  ldu_mq dut (
    .CLK                        (CLK),
    .RST                        (RST),
    .ldu_mq_enq_valid           (ldu_mq_enq_valid),
    .ldu_mq_enq_cq_index        (ldu_mq_enq_cq_index),
    .ldu_mq_enq_PO_word         (ldu_mq_enq_PO_word),
    .ldu_mq_enq_byte_mask       (ldu_mq_enq_byte_mask),
    .ldu_mq_enq_ready           (ldu_mq_enq_ready),
    .ldu_mq_enq_index           (ldu_mq_enq_index),
    .ldu_mq_info_grab_mq_index  (ldu_mq_info_grab_mq_index),
    .ldu_mq_info_grab_PA_word   (ldu_mq_info_grab_PA_word),
    .ldu_mq_info_ret_valid      (ldu_mq_info_ret_valid),
    .ldu_mq_info_ret_mq_index   (ldu_mq_info_ret_mq_index),
    .ldu_mq_info_ret_dtlb_hit   (ldu_mq_info_ret_dtlb_hit),
    .ldu_mq_info_ret_dcache_hit (ldu_mq_info_ret_dcache_hit),
    .ldu_mq_info_ret_is_mem     (ldu_mq_info_ret_is_mem),
    .ldu_mq_info_ret_aq_blocking(ldu_mq_info_ret_aq_blocking),
    .ldu_mq_info_ret_PPN        (ldu_mq_info_ret_PPN),
    .ldu_mq_info_ret_data       (ldu_mq_info_ret_data),
    .ldu_mq_wakeup_valid        (ldu_mq_wakeup_valid),
    .second_try_valid           (second_try_valid),
    .second_try_PPN             (second_try_PPN),
    .second_try_PO_word         (second_try_PO_word),
    .second_try_byte_mask       (second_try_byte_mask),
    .second_try_cq_index        (second_try_cq_index),
    .second_try_mq_index        (second_try_mq_index),
    .second_try_ack             (second_try_ack),
    .ldu_mq_done_valid          (ldu_mq_done_valid),
    .ldu_mq_done_cq_index       (ldu_mq_done_cq_index),
    .ldu_mq_done_tlb_miss       (ldu_mq_done_tlb_miss),
    .ldu_mq_done_is_mem         (ldu_mq_done_is_mem),
    .ldu_mq_done_data           (ldu_mq_done_data),
    .ldu_mq_dealloc_valid       (ldu_mq_dealloc_valid),
    .ldu_mq_dealloc_mq_index    (ldu_mq_dealloc_mq_index),
    .ldu_mq_flush_valid         (ldu_mq_flush_valid)
  );

  always #5 CLK = ~CLK;

  int n_chk  = 0;
  int n_pass = 0;

  // Reference model: one record per slot, updated from the spec rules
  mst_t            m_st   [N];
  logic [CQW-1:0]  m_cq   [N];
  logic [POW-1:0]  m_po   [N];
  logic [3:0]      m_mask [N];
  logic [PPNW-1:0] m_ppn  [N];
  bit              e_done_v;
  logic [CQW-1:0]  e_done_cq;
  bit              e_done_miss;
  bit              e_done_mem;
  logic [31:0]     e_done_data;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
  endtask

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      m_st[i] = M_FREE; m_cq[i] = '0; m_po[i] = '0; m_mask[i] = '0; m_ppn[i] = '0;
    end
    e_done_v = 0;
  endtask

  function automatic int lowest(input mst_t s [N], input mst_t want);
    for (int i = 0; i < N; i++) if (s[i] == want) return i;
    return -1;
  endfunction

  task automatic model_update();
    mst_t cur [N];
    int   fi, si, ri, di;
    cur = m_st;
    e_done_v = 0;
    if (ldu_mq_flush_valid) begin
      for (int i = 0; i < N; i++) m_st[i] = M_FREE;
      return;
    end
    fi = lowest(cur, M_FREE);
    si = lowest(cur, M_RDY);
    ri = int'(ldu_mq_info_ret_mq_index);
    di = int'(ldu_mq_dealloc_mq_index);
    if (ldu_mq_enq_valid && fi >= 0) begin
      m_st[fi] = M_WRET; m_cq[fi] = ldu_mq_enq_cq_index;
      m_po[fi] = ldu_mq_enq_PO_word; m_mask[fi] = ldu_mq_enq_byte_mask;
    end
    if (ldu_mq_info_ret_valid && cur[ri] == M_WRET) begin
      if (!ldu_mq_info_ret_dtlb_hit) begin
        m_st[ri] = M_DONE; e_done_v = 1; e_done_cq = m_cq[ri]; e_done_miss = 1;
      end else begin
        m_ppn[ri] = ldu_mq_info_ret_PPN;
        if (ldu_mq_info_ret_dcache_hit && !ldu_mq_info_ret_aq_blocking) begin
          m_st[ri] = M_DONE; e_done_v = 1; e_done_cq = m_cq[ri]; e_done_miss = 0;
          e_done_mem = ldu_mq_info_ret_is_mem; e_done_data = ldu_mq_info_ret_data;
        end else begin
          m_st[ri] = M_WWAKE;
        end
      end
    end
    if (ldu_mq_wakeup_valid)
      for (int i = 0; i < N; i++) if (cur[i] == M_WWAKE) m_st[i] = M_RDY;
    if (second_try_ack && si >= 0) m_st[si] = M_WRET;
    if (ldu_mq_dealloc_valid && cur[di] == M_DONE) m_st[di] = M_FREE;
  endtask

  task automatic check_outputs();
    int fi, si;
    fi = lowest(m_st, M_FREE);
    si = lowest(m_st, M_RDY);
    chk("enq_ready", 64'(ldu_mq_enq_ready), 64'(fi >= 0));
    chk("enq_index", 64'(ldu_mq_enq_index), 64'((fi >= 0) ? fi : 0));
    chk("grab_pa", 64'(ldu_mq_info_grab_PA_word), 64'(m_ppn[ldu_mq_info_grab_mq_index]));
    chk("st_valid", 64'(second_try_valid), 64'(si >= 0));
    if (si >= 0) begin
      chk("st_ppn", 64'(second_try_PPN), 64'(m_ppn[si]));
      chk("st_po", 64'(second_try_PO_word), 64'(m_po[si]));
      chk("st_mask", 64'(second_try_byte_mask), 64'(m_mask[si]));
      chk("st_cq", 64'(second_try_cq_index), 64'(m_cq[si]));
      chk("st_mq", 64'(second_try_mq_index), 64'(si));
    end
    chk("done_valid", 64'(ldu_mq_done_valid), 64'(e_done_v));
    if (e_done_v) begin
      chk("done_cq", 64'(ldu_mq_done_cq_index), 64'(e_done_cq));
      chk("done_miss", 64'(ldu_mq_done_tlb_miss), 64'(e_done_miss));
      if (!e_done_miss) begin
        chk("done_mem", 64'(ldu_mq_done_is_mem), 64'(e_done_mem));
        chk("done_data", 64'(ldu_mq_done_data), 64'(e_done_data));
      end
    end
  endtask

  // Inputs are held from posedge+1; outputs are checked at posedge+2
  task automatic cycle();
    #1;
    check_outputs();
    @(posedge CLK);
    model_update();
    #1;
  endtask

  task automatic idle();
    ldu_mq_enq_valid = 0; ldu_mq_enq_cq_index = '0;
    ldu_mq_enq_PO_word = POW'($urandom); ldu_mq_enq_byte_mask = 4'($urandom);
    ldu_mq_info_grab_mq_index = LOGN'($urandom);
    ldu_mq_info_ret_valid = 0; ldu_mq_info_ret_mq_index = '0;
    ldu_mq_info_ret_dtlb_hit = 0; ldu_mq_info_ret_dcache_hit = 0;
    ldu_mq_info_ret_is_mem = 0; ldu_mq_info_ret_aq_blocking = 0;
    ldu_mq_info_ret_PPN = '0; ldu_mq_info_ret_data = '0;
    ldu_mq_wakeup_valid = 0; second_try_ack = 0;
    ldu_mq_dealloc_valid = 0; ldu_mq_dealloc_mq_index = '0;
    ldu_mq_flush_valid = 0;
  endtask

  task automatic rand_inputs();
    ldu_mq_enq_valid            = ($urandom_range(0, 1) == 1);
    ldu_mq_enq_cq_index         = CQW'($urandom);
    ldu_mq_enq_PO_word          = POW'($urandom);
    ldu_mq_enq_byte_mask        = 4'($urandom);
    ldu_mq_info_grab_mq_index   = LOGN'($urandom);
    ldu_mq_info_ret_valid       = ($urandom_range(0, 1) == 1);
    ldu_mq_info_ret_mq_index    = LOGN'($urandom);
    ldu_mq_info_ret_dtlb_hit    = ($urandom_range(0, 7) != 0);
    ldu_mq_info_ret_dcache_hit  = ($urandom_range(0, 1) == 1);
    ldu_mq_info_ret_is_mem      = ($urandom_range(0, 1) == 1);
    ldu_mq_info_ret_aq_blocking = ($urandom_range(0, 3) == 0);
    ldu_mq_info_ret_PPN         = PPNW'($urandom);
    ldu_mq_info_ret_data        = $urandom;
    ldu_mq_wakeup_valid         = ($urandom_range(0, 3) == 0);
    second_try_ack              = ($urandom_range(0, 1) == 1);
    ldu_mq_dealloc_valid        = ($urandom_range(0, 2) == 0);
    ldu_mq_dealloc_mq_index     = LOGN'($urandom);
    ldu_mq_flush_valid          = ($urandom_range(0, 63) == 0);
  endtask

  task automatic enq(input logic [CQW-1:0] cq);
    idle(); ldu_mq_enq_valid = 1; ldu_mq_enq_cq_index = cq; cycle();
  endtask

  task automatic ret(input int idx, input bit dtlb, input bit dc, input bit aq, input bit mem,
                     input logic [PPNW-1:0] ppn, input logic [31:0] data);
    idle();
    ldu_mq_info_ret_valid = 1; ldu_mq_info_ret_mq_index = LOGN'(idx);
    ldu_mq_info_ret_dtlb_hit = dtlb; ldu_mq_info_ret_dcache_hit = dc;
    ldu_mq_info_ret_aq_blocking = aq; ldu_mq_info_ret_is_mem = mem;
    ldu_mq_info_ret_PPN = ppn; ldu_mq_info_ret_data = data;
    cycle();
  endtask

  task automatic wakeup();   idle(); ldu_mq_wakeup_valid = 1; cycle(); endtask
  task automatic ack();      idle(); second_try_ack = 1; cycle(); endtask
  task automatic flush();    idle(); ldu_mq_flush_valid = 1; cycle(); endtask
  task automatic dealloc(input int idx);
    idle(); ldu_mq_dealloc_valid = 1; ldu_mq_dealloc_mq_index = LOGN'(idx); cycle();
  endtask

  task automatic reset_checks(input string pfx);
    chk({pfx, "_enq_ready"}, 64'(ldu_mq_enq_ready), 64'(1));
    chk({pfx, "_enq_index"}, 64'(ldu_mq_enq_index), 64'(0));
    chk({pfx, "_st_valid"},  64'(second_try_valid), 64'(0));
    chk({pfx, "_st_ppn"},    64'(second_try_PPN), 64'(0));
    chk({pfx, "_done_valid"}, 64'(ldu_mq_done_valid), 64'(0));
    chk({pfx, "_done_cq"},   64'(ldu_mq_done_cq_index), 64'(0));
    chk({pfx, "_done_data"}, 64'(ldu_mq_done_data), 64'(0));
    chk({pfx, "_grab_pa"},   64'(ldu_mq_info_grab_PA_word), 64'(0));
  endtask

  initial begin
    logic [CQW-1:0] cq_list [4];
    cq_list = '{4'd3, 4'd5, 4'd7, 4'd9};
    RST = 1;
    idle();
    model_reset();
    repeat (2) @(posedge CLK);
    #1;
    reset_checks("rst");
    RST = 0;

    // Fill all four slots, then try a fifth
    for (int k = 0; k < 4; k++) begin
      chk("fill_enq_index", 64'(ldu_mq_enq_index), 64'(k));
      enq(cq_list[k]);
    end
    chk("full_enq_ready", 64'(ldu_mq_enq_ready), 64'(0));
    enq(4'd11);
    chk("full_still", 64'(ldu_mq_enq_ready), 64'(0));
    flush();

    // Straight hit on the first RET
    enq(4'd5);
    ret(0, 1, 1, 0, 1, 22'h0ABCD, 32'hDEADBEEF);
    chk("hit_done_valid", 64'(ldu_mq_done_valid), 64'(1));
    chk("hit_done_cq", 64'(ldu_mq_done_cq_index), 64'(5));
    chk("hit_done_data", 64'(ldu_mq_done_data), 64'(32'hDEADBEEF));
    chk("hit_done_miss", 64'(ldu_mq_done_tlb_miss), 64'(0));
    idle(); cycle();
    dealloc(0);

    // Miss, wake, re-issue, hit
    enq(4'd2);
    ret(0, 1, 0, 0, 0, 22'h12345, 32'h0);
    wakeup();
    chk("wake_st_valid", 64'(second_try_valid), 64'(1));
    chk("wake_st_ppn", 64'(second_try_PPN), 64'(22'h12345));
    chk("wake_st_mq", 64'(second_try_mq_index), 64'(0));
    ack();
    chk("ack_st_valid", 64'(second_try_valid), 64'(0));
    ret(0, 1, 1, 0, 0, 22'h12345, 32'h600DF00D);
    chk("retry_done_valid", 64'(ldu_mq_done_valid), 64'(1));
    chk("retry_done_cq", 64'(ldu_mq_done_cq_index), 64'(2));
    dealloc(0);

    // Priority between two READY entries, then tlb miss and dealloc
    for (int k = 0; k < 4; k++) enq(CQW'(k + 1));
    ret(1, 1, 0, 0, 1, 22'h0AAAA, 32'h0);
    ret(3, 1, 1, 1, 0, 22'h0BBBB, 32'h0);
    wakeup();
    chk("prio_st_mq", 64'(second_try_mq_index), 64'(1));
    chk("prio_st_cq", 64'(second_try_cq_index), 64'(2));
    ack();
    chk("prio_next_mq", 64'(second_try_mq_index), 64'(3));
    chk("prio_next_ppn", 64'(second_try_PPN), 64'(22'h0BBBB));
    ret(2, 0, 1, 0, 1, 22'h3FFFF, 32'h1);
    chk("miss_done_valid", 64'(ldu_mq_done_valid), 64'(1));
    chk("miss_done_flag", 64'(ldu_mq_done_tlb_miss), 64'(1));
    chk("miss_done_cq", 64'(ldu_mq_done_cq_index), 64'(3));
    chk("dealloc_before", 64'(ldu_mq_enq_ready), 64'(0));
    dealloc(2);
    chk("dealloc_ready", 64'(ldu_mq_enq_ready), 64'(1));
    chk("dealloc_index", 64'(ldu_mq_enq_index), 64'(2));

    // Flush beats a concurrent hit
    idle();
    ldu_mq_flush_valid = 1;
    ldu_mq_info_ret_valid = 1; ldu_mq_info_ret_mq_index = '0;
    ldu_mq_info_ret_dtlb_hit = 1; ldu_mq_info_ret_dcache_hit = 1;
    cycle();
    chk("flush_done_valid", 64'(ldu_mq_done_valid), 64'(0));
    chk("flush_enq_index", 64'(ldu_mq_enq_index), 64'(0));
    chk("flush_enq_ready", 64'(ldu_mq_enq_ready), 64'(1));
    chk("flush_st_valid", 64'(second_try_valid), 64'(0));

    // Random traffic with an asynchronous reset in the middle
    for (int c = 0; c < 3000; c++) begin
      rand_inputs();
      if (c == 1500) begin
        #3 RST = 1;
        #1 reset_checks("arst");
        model_reset();
        @(posedge CLK);
        #1 RST = 0;
        rand_inputs();
      end
      cycle();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
